// File: rtl/jt49_div_bank.sv
// jt49_div_bank: CH independent programmable dividers (square/pulse) with a 1-clk terminal strobe.
// Define JT49_DIV_SHADOW_EN to latch each period into a shadow register at terminal/restart.
module jt49_div_lane #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_cen,
    input  logic         i_restart,
    input  logic         i_mode,
    input  logic [W-1:0] i_period,
    output logic         o_div,
    output logic         o_tick
);
    logic [W-1:0] r_count;
    logic         r_div;
    logic         r_tick;
    logic [W-1:0] w_per;
    logic [W-1:0] w_eff;
    logic         w_term;

`ifdef JT49_DIV_SHADOW_EN
    logic [W-1:0] r_act_per;

    // Zero after reset so the very first cen is terminal and picks up the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_act_per <= '0;
        else if (i_restart || (i_cen && w_term))
            r_act_per <= i_period;
    end

    assign w_per = r_act_per;
`else
    assign w_per = i_period;
`endif

    assign w_eff  = (w_per == '0) ? W'(1) : w_per;
    // >= rather than == so a period lowered below the count ends the interval on the next cen.
    assign w_term = (r_count >= w_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= W'(1);
            r_div   <= 1'b0;
            r_tick  <= 1'b0;
        end else if (i_restart) begin
            r_count <= W'(1);
            r_div   <= 1'b0;
            r_tick  <= 1'b0;
        end else if (i_cen) begin
            if (w_term) begin
                r_count <= W'(1);
                r_tick  <= 1'b1;
                r_div   <= i_mode ? 1'b1 : ~r_div;
            end else begin
                r_count <= r_count + W'(1);
                r_tick  <= 1'b0;
                if (i_mode)
                    r_div <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o_div  = r_div;
    assign o_tick = r_tick;
endmodule

module jt49_div_bank #(
    parameter int CH = 3,
    parameter int W  = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic [CH*W-1:0] period,
    input  logic [CH-1:0] mode,
    input  logic [CH-1:0] restart,
    output logic [CH-1:0] div,
    output logic [CH-1:0] tick
);
    logic [CH-1:0][W-1:0] w_period;

    assign w_period = period;

    for (genvar n = 0; n < CH; n++) begin : g_lane
        jt49_div_lane #(.W(W)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_cen    (cen),
            .i_restart(restart[n]),
            .i_mode   (mode[n]),
            .i_period (w_period[n]),
            .o_div    (div[n]),
            .o_tick   (tick[n])
        );
    end
endmodule
